// File: rtl/banked_memory.sv
// banked_memory
//   Word-interleaved multi-bank buffer shared by several read requesters and
//   a single byte-masked write stream. Each bank arbitrates its own read
//   requesters round-robin. Reads are registered and have one cycle of latency.
//   A write never blocks a read. A read and a write to the same word at the
//   same edge return the old contents (read-first).
//
// Ports
//   clk           clock; all state changes on the rising edge
//   arst_n_in     synchronous active-low reset
//   rd_req_valid  per-port read request valid
//   rd_addr       per-port read word address
//   rd_req_ready  per-port grant, combinational, held low during reset
//   rd_rsp_valid  per-port one-cycle response pulse
//   rd_data       per-port read data; holds its value between responses
//   write_en      write strobe
//   write_addr    write word address
//   din           write data
//   write_mask    byte enables; bit i covers din[8i+7:8i]
module banked_memory #(
    parameter int WIDTH                = 16,
    parameter int HEIGHT               = 64,
    parameter int NUM_BANKS            = 4,
    parameter int NUM_RD_PORTS         = 2,
    parameter int USED_AS_EXTERNAL_MEM = 0
) (
    input  logic                                        clk,
    input  logic                                        arst_n_in,
    input  logic [NUM_RD_PORTS-1:0]                     rd_req_valid,
    input  logic [NUM_RD_PORTS-1:0][$clog2(HEIGHT)-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]                     rd_req_ready,
    output logic [NUM_RD_PORTS-1:0]                     rd_rsp_valid,
    output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]          rd_data,
    input  logic                                        write_en,
    input  logic [$clog2(HEIGHT)-1:0]                   write_addr,
    input  logic [WIDTH-1:0]                            din,
    input  logic [WIDTH/8-1:0]                          write_mask
);

    localparam int AW    = $clog2(HEIGHT);
    localparam int ROWS  = HEIGHT / NUM_BANKS;
    localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW    = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int BYTES = WIDTH / 8;

    logic [WIDTH-1:0]        mem [NUM_BANKS][ROWS];
    logic [PW-1:0]           rr_ptr [NUM_BANKS];
    logic [PW-1:0]           rr_ptr_next [NUM_BANKS];
    logic [NUM_BANKS-1:0]    bank_taken;
    logic [NUM_RD_PORTS-1:0] grant;

    // Low address bits select the bank, so consecutive words land in different banks.
    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
        return BW'(int'(a) % NUM_BANKS);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return RW'(int'(a) / NUM_BANKS);
    endfunction

    // Per-bank round-robin. The outer loop walks the priority order starting
    // at rr_ptr. The first valid requester for this bank claims the bank.
    always_comb begin
        grant      = '0;
        bank_taken = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_next[b] = rr_ptr[b];
            for (int o = 0; o < NUM_RD_PORTS; o++) begin
                for (int p = 0; p < NUM_RD_PORTS; p++) begin
                    if (!bank_taken[b] && rd_req_valid[p] &&
                        bank_of(rd_addr[p]) == BW'(b) &&
                        p == (int'(rr_ptr[b]) + o) % NUM_RD_PORTS) begin
                        grant[p]       = 1'b1;
                        bank_taken[b]  = 1'b1;
                        rr_ptr_next[b] = PW'((p + 1) % NUM_RD_PORTS);
                    end
                end
            end
        end
    end

    assign rd_req_ready = grant & {NUM_RD_PORTS{arst_n_in}};

    // Response stage: registered read data with the valid pulse alongside.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            rd_rsp_valid <= '0;
            rd_data      <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            rd_rsp_valid <= grant;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= rr_ptr_next[b];
            end
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (grant[p]) begin
                    rd_data[p] <= mem[bank_of(rd_addr[p])][row_of(rd_addr[p])];
                end
            end
        end
    end

    // Write port. The non-blocking update makes a same-edge read see the old word.
    always_ff @(posedge clk) begin
        if (arst_n_in && write_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (write_mask[i]) begin
                    mem[bank_of(write_addr)][row_of(write_addr)][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Energy accounting for simulation only. One unit of WIDTH per accepted
    // read and per write that has at least one byte enabled.
    localparam real ENERGY_WEIGHT = (USED_AS_EXTERNAL_MEM != 0) ? 1.0 : 0.1;
    real energy_acc = 0.0;

    always_ff @(posedge clk) begin
        if (arst_n_in) begin
            energy_acc <= energy_acc +
                real'($countones(grant) + ((write_en && (|write_mask)) ? 1 : 0)) *
                real'(WIDTH) * ENERGY_WEIGHT;
        end
    end
`endif

endmodule

// File: tb/tb_banked_memory.sv
module tb_banked_memory;

    localparam int WIDTH  = 16;
    localparam int HEIGHT = 64;
    localparam int NP     = 2;
    localparam int AW     = 6;

    logic                        clk = 1'b0;
    logic                        arst_n_in;
    logic [NP-1:0]               rd_req_valid;
    logic [NP-1:0][AW-1:0]       rd_addr;
    logic [NP-1:0]               rd_req_ready;
    logic [NP-1:0]               rd_rsp_valid;
    logic [NP-1:0][WIDTH-1:0]    rd_data;
    logic                        write_en;
    logic [AW-1:0]               write_addr;
    logic [WIDTH-1:0]            din;
    logic [1:0]                  write_mask;

    always #5 clk = ~clk;

    banked_memory #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_BANKS(4), .NUM_RD_PORTS(NP),
        .USED_AS_EXTERNAL_MEM(0)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .rd_req_valid(rd_req_valid), .rd_addr(rd_addr), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_data(rd_data),
        .write_en(write_en), .write_addr(write_addr), .din(din), .write_mask(write_mask)
    );

    int tests = 0;
    int fails = 0;

    // Reference contents and per-port queues of expected responses.
    logic [WIDTH-1:0] model [HEIGHT];
    logic [WIDTH-1:0] exp_q0 [$];
    logic [WIDTH-1:0] exp_q1 [$];

    // Handshake and write inputs sampled mid-cycle. Inputs change only just after a rising edge.
    logic [NP-1:0]         cap_acc   = '0;
    logic [NP-1:0][AW-1:0] cap_addr  = '0;
    logic                  cap_rst_n = 1'b0;
    logic                  cap_we    = 1'b0;
    logic [AW-1:0]         cap_waddr = '0;
    logic [WIDTH-1:0]      cap_din   = '0;
    logic [1:0]            cap_mask  = '0;
    logic [WIDTH-1:0]      mon_exp;
    bit                    mon_have;

    function automatic logic [WIDTH-1:0] pre(input int a);
        return 16'(a * 257) ^ 16'h5A00;
    endfunction

    always @(negedge clk) begin
        cap_acc   = rd_req_valid & rd_req_ready;
        cap_addr  = rd_addr;
        cap_rst_n = arst_n_in;
        cap_we    = write_en;
        cap_waddr = write_addr;
        cap_din   = din;
        cap_mask  = write_mask;
    end

    // Scoreboard: push on an accepted request, then check the response just after the edge.
    always @(posedge clk) begin
        if (cap_rst_n) begin
            if (cap_acc[0]) exp_q0.push_back(model[cap_addr[0]]);
            if (cap_acc[1]) exp_q1.push_back(model[cap_addr[1]]);
            if (cap_we) begin
                for (int i = 0; i < 2; i++) begin
                    if (cap_mask[i]) model[cap_waddr][8*i +: 8] = cap_din[8*i +: 8];
                end
            end
        end
        #1;
        for (int p = 0; p < NP; p++) begin
            mon_have = 1'b0;
            mon_exp  = '0;
            if (p == 0 && exp_q0.size() > 0) begin mon_exp = exp_q0.pop_front(); mon_have = 1'b1; end
            if (p == 1 && exp_q1.size() > 0) begin mon_exp = exp_q1.pop_front(); mon_have = 1'b1; end
            tests++;
            if (mon_have) begin
                if (rd_rsp_valid[p] !== 1'b1 || rd_data[p] !== mon_exp) begin
                    fails++;
                    $display("FAIL rsp_port%0d at %0t: got valid=%b data=%h, required valid=1 data=%h",
                             p, $time, rd_rsp_valid[p], rd_data[p], mon_exp);
                end
            end else if (rd_rsp_valid[p] !== 1'b0) begin
                fails++;
                $display("FAIL idle_port%0d at %0t: got valid=%b, required valid=0",
                         p, $time, rd_rsp_valid[p]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk2(input string name, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic drive_rd(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_req_valid = v;
        rd_addr[0]   = a0;
        rd_addr[1]   = a1;
    endtask

    task automatic drive_wr(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                            input logic [1:0] m);
        write_en   = we;
        write_addr = a;
        din        = d;
        write_mask = m;
    endtask

    typedef struct {
        logic [1:0]    valid;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    exp_ready;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    initial begin
        // Consecutive cycles. A port that is not granted keeps its request on the next row.
        vec[0]  = '{2'b11, 6'd2,  6'd6,  2'b01};  // bank 2 conflict, p0 first
        vec[1]  = '{2'b11, 6'd2,  6'd6,  2'b10};
        vec[2]  = '{2'b11, 6'd2,  6'd6,  2'b01};
        vec[3]  = '{2'b11, 6'd2,  6'd6,  2'b10};
        vec[4]  = '{2'b11, 6'd1,  6'd2,  2'b11};  // different banks in parallel
        vec[5]  = '{2'b11, 6'd5,  6'd1,  2'b10};  // bank 1 pointer at p1
        vec[6]  = '{2'b11, 6'd5,  6'd13, 2'b01};
        vec[7]  = '{2'b11, 6'd13, 6'd13, 2'b10};  // same address still conflicts
        vec[8]  = '{2'b11, 6'd13, 6'd7,  2'b11};
        vec[9]  = '{2'b01, 6'd0,  6'd0,  2'b01};
        vec[10] = '{2'b10, 6'd0,  6'd4,  2'b10};
        vec[11] = '{2'b11, 6'd4,  6'd8,  2'b01};
        vec[12] = '{2'b11, 6'd12, 6'd8,  2'b10};
        vec[13] = '{2'b11, 6'd12, 6'd3,  2'b11};
        vec[14] = '{2'b00, 6'd0,  6'd0,  2'b00};

        arst_n_in = 1'b0;
        drive_rd(2'b00, 6'd0, 6'd0);
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        repeat (3) tick();
        chk2("reset_rsp_valid", rd_rsp_valid, 2'b00);
        chk16("reset_data0", rd_data[0], 16'h0000);
        chk16("reset_data1", rd_data[1], 16'h0000);

        // Fill every word so that all later reads have defined contents.
        arst_n_in = 1'b1;
        for (int a = 0; a < HEIGHT; a++) begin
            drive_wr(1'b1, AW'(a), pre(a), 2'b11);
            tick();
        end
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);

        // Full write, then read on the next cycle.
        drive_wr(1'b1, 6'd5, 16'hABCD, 2'b11);
        tick();
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        drive_rd(2'b01, 6'd5, 6'd0);
        #1 chk2("wr_read_ready", rd_req_ready, 2'b01);
        tick();
        drive_rd(2'b00, 6'd0, 6'd0);
        chk2("wr_read_rsp_valid", rd_rsp_valid, 2'b01);
        chk16("wr_read_data", rd_data[0], 16'hABCD);

        // Masked write of the low byte only.
        drive_wr(1'b1, 6'd5, 16'h1234, 2'b01);
        tick();
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        drive_rd(2'b01, 6'd5, 6'd0);
        tick();
        drive_rd(2'b00, 6'd0, 6'd0);
        chk16("masked_write_data", rd_data[0], 16'hAB34);

        // A write with an all-zero mask changes nothing.
        drive_wr(1'b1, 6'd5, 16'hFFFF, 2'b00);
        tick();
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        drive_rd(2'b01, 6'd5, 6'd0);
        tick();
        drive_rd(2'b00, 6'd0, 6'd0);
        chk16("zero_mask_data", rd_data[0], 16'hAB34);
        chk16("idle_data_hold", rd_data[0], 16'hAB34);

        // Arbitration table.
        for (int i = 0; i < NV; i++) begin
            drive_rd(vec[i].valid, vec[i].a0, vec[i].a1);
            #1 chk2($sformatf("vec%0d_ready", i), rd_req_ready, vec[i].exp_ready);
            tick();
        end
        drive_rd(2'b00, 6'd0, 6'd0);

        // Read and write to the same word at the same edge.
        drive_wr(1'b1, 6'd9, 16'h0F0F, 2'b11);
        tick();
        drive_wr(1'b1, 6'd9, 16'h5555, 2'b11);
        drive_rd(2'b01, 6'd9, 6'd0);
        #1 chk2("same_edge_ready", rd_req_ready, 2'b01);
        tick();
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        chk16("read_first_old", rd_data[0], 16'h0F0F);
        tick();
        drive_rd(2'b00, 6'd0, 6'd0);
        chk16("read_after_write_new", rd_data[0], 16'h5555);

        // Move the bank 0 pointer to port 1 so that reset has something to clear.
        drive_rd(2'b01, 6'd0, 6'd0);
        tick();
        arst_n_in = 1'b0;
        drive_rd(2'b11, 6'd0, 6'd4);
        drive_wr(1'b1, 6'd3, 16'hDEAD, 2'b11);
        #1 chk2("in_reset_ready", rd_req_ready, 2'b00);
        tick();
        chk2("in_reset_rsp_valid", rd_rsp_valid, 2'b00);
        chk16("in_reset_data0", rd_data[0], 16'h0000);
        tick();
        arst_n_in = 1'b1;
        drive_wr(1'b0, 6'd0, 16'h0, 2'b00);
        #1 chk2("release_first_grant", rd_req_ready, 2'b01);
        tick();
        #1 chk2("release_second_grant", rd_req_ready, 2'b10);
        tick();
        drive_rd(2'b01, 6'd3, 6'd0);
        tick();
        drive_rd(2'b00, 6'd0, 6'd0);
        chk16("write_in_reset_ignored", rd_data[0], pre(3));

        // Reset while a request is held right after an accepted read.
        drive_rd(2'b01, 6'd1, 6'd0);
        tick();
        arst_n_in = 1'b0;
        tick();
        chk2("reset_drops_rsp", rd_rsp_valid, 2'b00);
        chk16("reset_clears_data", rd_data[0], 16'h0000);
        arst_n_in = 1'b1;
        drive_rd(2'b00, 6'd0, 6'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
